// File: rtl/data_chk_pkg.sv
// Shared types and constants for the data_chk stream checker.
package data_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1 taps bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic lfsr_feedback(input logic [15:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/data_chk_lfsr.sv
// 16-bit Fibonacci LFSR with enable; source of back-pressure for data_chk.
module data_chk_lfsr
  import data_chk_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] q
);

  // LFSR state: reseeded on reset, shifts only while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {lfsr_feedback(q), q[15:1]};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/data_chk.sv
// AXI-Stream sink that checks a counting pattern and tlast placement.
// Optional pseudo-random back-pressure is enabled by defining DATA_CHK_BP_EN.
module data_chk
  import data_chk_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ERR_W = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic [31:0]      size,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [31:0]      beat_cnt,
  output logic [ERR_W-1:0] err_cnt,
  output logic             last_err,
  output logic             pass
);

  state_t      state_r;
  state_t      state_s;
  logic [31:0] size_q_r;
  logic        accept_s;
  logic        final_beat_s;
  logic        bp_ok_s;

`ifdef DATA_CHK_BP_EN
  logic [15:0] lfsr_s;

  data_chk_lfsr u_lfsr (
    .clk (ap_clk),
    .rst (ap_rst),
    .en  (state_r == RUN),
    .q   (lfsr_s)
  );

  assign bp_ok_s = lfsr_s[0];
`else
  assign bp_ok_s = 1'b1;
`endif

  assign accept_s     = (state_r == RUN) && s_axis_tvalid && s_axis_tready;
  assign final_beat_s = (beat_cnt == (size_q_r - 32'd1));

  // Next-state: a transaction ends on any tlast or on the final expected beat.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          state_s = (size == 32'd0) ? DONE : RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s && (s_axis_tlast || final_beat_s)) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, handshake outputs and result counters.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r       <= IDLE;
      size_q_r      <= 32'd0;
      ap_done       <= 1'b0;
      ap_ready      <= 1'b0;
      ap_idle       <= 1'b1;
      s_axis_tready <= 1'b0;
      beat_cnt      <= 32'd0;
      err_cnt       <= '0;
      last_err      <= 1'b0;
      pass          <= 1'b0;
    end else begin
      state_r       <= state_s;
      ap_idle       <= (state_s == IDLE);
      s_axis_tready <= (state_s == RUN) && bp_ok_s;
      ap_done       <= (state_r == DONE);
      ap_ready      <= (state_r == DONE);
      if ((state_r == IDLE) && ap_start) begin
        size_q_r <= size;
        beat_cnt <= 32'd0;
        err_cnt  <= '0;
        last_err <= 1'b0;
        pass     <= 1'b0;
      end else if (accept_s) begin
        beat_cnt <= beat_cnt + 32'd1;
        // Expected pattern is the beat index truncated (or zero-extended) to WIDTH.
        if ((s_axis_tdata != WIDTH'(beat_cnt)) && (err_cnt != {ERR_W{1'b1}})) begin
          err_cnt <= err_cnt + ERR_W'(1);
        end
        if (s_axis_tlast != final_beat_s) begin
          last_err <= 1'b1;
        end
      end else if (state_r == DONE) begin
        pass <= (err_cnt == '0) && !last_err && (beat_cnt == size_q_r);
      end
    end
  end

endmodule
